ysyx_23060061_ifu: RTL and testbench

//   Multi-cycle instruction fetch unit, directly upstream of the decoder/execute datapath.

---
 rtl/ysyx_23060061_pkg.sv | 20 ++
 rtl/ysyx_23060061_ifu_if.sv | 39 +++
 rtl/ysyx_23060061_Reg.sv | 23 ++
 rtl/ysyx_23060061_ifu.sv | 109 ++++++++++
 tb/tb_ysyx_23060061_ifu.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060061_pkg.sv
// Shared IFU definitions: state encoding and fixed
// bus/instruction constants.
package ysyx_23060061_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2,
        S_NPC  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    // Instructions are 4-byte aligned; low bits must be zero.
    function automatic logic pc_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060061_ifu_if.sv
// IFU-facing bundle: AR/R fetch bus, decoder output
// handshake and dnpc return handshake.
interface ysyx_23060061_ifu_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] araddr;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_fault;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] dnpc;
    logic            dnpc_valid;
    logic            dnpc_ready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output out_inst, out_pc, out_fault, out_valid,
        input  out_ready,
        input  dnpc, dnpc_valid,
        output dnpc_ready
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  out_inst, out_pc, out_fault, out_valid,
        output out_ready,
        output dnpc, dnpc_valid,
        input  dnpc_ready
    );
endinterface

// File: rtl/ysyx_23060061_Reg.sv
// Generic register with write enable and
// asynchronous reset to a fixed value.
module ysyx_23060061_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    output logic [WIDTH-1:0] dout
);

    // Load din when enabled, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// Multi-cycle instruction fetch unit: one fetch per PC,
// bundle to decoder, then wait for the committed dnpc.
module ysyx_23060061_ifu
    import ysyx_23060061_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060061_ifu_if.master       bus
);

    ifu_state_e      state;
    ifu_state_e      state_nxt;
    logic            armed;
    logic [XLEN-1:0] pc;
    logic            pc_wen;
    logic            ar_fire;
    logic            r_fire;
    logic            o_fire;
    logic            npc_ok;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] opc_q;
    logic            fault_q;

    assign ar_fire = bus.arvalid & bus.arready;
    assign r_fire  = bus.rready & bus.rvalid;
    assign o_fire  = bus.out_valid & bus.out_ready;
    assign pc_wen  = bus.dnpc_valid & bus.dnpc_ready;
    assign npc_ok  = pc_aligned(bus.dnpc[1:0]);

    ysyx_23060061_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.dnpc),
        .wen  (pc_wen),
        .dout (pc)
    );

    // State register; armed holds off arvalid until the
    // first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // Next-state logic for the request/response/out/npc loop.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ:  if (ar_fire) state_nxt = S_RESP;
            S_RESP: if (r_fire)  state_nxt = S_OUT;
            S_OUT:  if (o_fire)  state_nxt = S_NPC;
            S_NPC: begin
                if (pc_wen) begin
                    state_nxt = npc_ok ? S_REQ : S_OUT;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Bundle latch: fetched word, or a nop fault for a bus
    // error or a misaligned dnpc that skips the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= '0;
            opc_q   <= RESET_PC;
            fault_q <= 1'b0;
        end else if (r_fire) begin
            inst_q  <= (bus.rresp == RESP_OKAY) ? bus.rdata : INST_NOP;
            fault_q <= (bus.rresp != RESP_OKAY);
            opc_q   <= pc;
        end else if (pc_wen && !npc_ok) begin
            inst_q  <= INST_NOP;
            fault_q <= 1'b1;
            opc_q   <= bus.dnpc;
        end
    end

    // Handshake strobes decode directly from the state.
    always_comb begin
        bus.araddr     = pc;
        bus.arvalid    = 1'b0;
        bus.rready     = 1'b0;
        bus.out_valid  = 1'b0;
        bus.dnpc_ready = 1'b0;
        bus.out_inst   = inst_q;
        bus.out_pc     = opc_q;
        bus.out_fault  = fault_q;
        unique case (state)
            S_REQ:   bus.arvalid    = armed;
            S_RESP:  bus.rready     = 1'b1;
            S_OUT:   bus.out_valid  = 1'b1;
            S_NPC:   bus.dnpc_ready = 1'b1;
            default: bus.arvalid    = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Self-checking bench for the IFU: directed table,
// random transactions against a bundle model, reset cases.
module tb_ysyx_23060061_ifu;
    import ysyx_23060061_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    string cur_tag = "init";

    always #5 clk = ~clk;

    ysyx_23060061_ifu_if u ();

    ysyx_23060061_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (u.master)
    );

    typedef struct {
        bit          misal;
        int          ar_wait;
        int          r_wait;
        int          out_wait;
        int          npc_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] dnpc;
        logic [31:0] exp_inst;
        logic        exp_fault;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %08h want %08h", cur_tag, nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0b want %0b", cur_tag, nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input bit misal, input int aw, input int rw,
                                 input int ow, input int nw, input logic [31:0] rd,
                                 input logic [1:0] rr, input logic [31:0] npc,
                                 input logic [31:0] ei, input logic ef,
                                 input logic [31:0] ep);
        vec_t v;
        v.misal = misal; v.ar_wait = aw; v.r_wait = rw;
        v.out_wait = ow; v.npc_wait = nw; v.rdata = rd;
        v.rresp = rr; v.dnpc = npc; v.exp_inst = ei;
        v.exp_fault = ef; v.exp_pc = ep;
        return v;
    endfunction

    // Reference: what the decoder must see for a fetch at pc.
    function automatic vec_t ref_model(input logic [31:0] pc, input logic [31:0] rd,
                                       input logic [1:0] rr, input logic [31:0] npc);
        vec_t v;
        v = mkv(0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2),
                rd, rr, npc, 32'h0, 1'b0, pc);
        if (pc % 4 != 0) begin
            v.misal = 1;
            v.exp_inst = 32'h0000_0013;
            v.exp_fault = 1'b1;
        end else if (rr != 2'b00) begin
            v.exp_inst = 32'h0000_0013;
            v.exp_fault = 1'b1;
        end else begin
            v.exp_inst = rd;
        end
        return v;
    endfunction

    task automatic check_bundle(input vec_t v);
        chkb("out_valid", u.out_valid, 1'b1);
        chk32("out_inst", u.out_inst, v.exp_inst);
        chk32("out_pc", u.out_pc, v.exp_pc);
        chkb("out_fault", u.out_fault, v.exp_fault);
    endtask

    // Drives one full fetch transaction; starts and ends on a negedge.
    task automatic run_vec(input vec_t v);
        int n;
        if (!v.misal) begin
            n = 0;
            while (u.arvalid !== 1'b1 && n < 20) begin
                cyc();
                n++;
            end
            chkb("ar_seen", u.arvalid, 1'b1);
            chk32("araddr", u.araddr, v.exp_pc);
            for (int i = 0; i < v.ar_wait; i++) begin
                u.rvalid = 1'b1;
                u.rdata = $urandom;
                cyc();
                chkb("ar_hold", u.arvalid, 1'b1);
                chk32("ar_stable", u.araddr, v.exp_pc);
                chkb("rready_lo", u.rready, 1'b0);
            end
            u.arready = 1'b1;
            u.rvalid = 1'b1;
            u.rdata = $urandom;
            cyc();
            u.arready = 1'b0;
            u.rvalid = 1'b0;
            chkb("rready", u.rready, 1'b1);
            chkb("ar_drop", u.arvalid, 1'b0);
            for (int i = 0; i < v.r_wait; i++) begin
                cyc();
                chkb("rready_hold", u.rready, 1'b1);
                chkb("out_early", u.out_valid, 1'b0);
            end
            u.rvalid = 1'b1;
            u.rdata = v.rdata;
            u.rresp = v.rresp;
            cyc();
            u.rvalid = 1'b0;
            u.rdata = $urandom;
            u.rresp = 2'($urandom);
        end else begin
            chkb("no_ar", u.arvalid, 1'b0);
        end
        check_bundle(v);
        for (int i = 0; i < v.out_wait; i++) begin
            u.dnpc_valid = 1'b1;
            u.dnpc = v.dnpc;
            cyc();
            chkb("dnpc_rdy_lo", u.dnpc_ready, 1'b0);
            check_bundle(v);
        end
        u.out_ready = 1'b1;
        u.dnpc_valid = 1'b1;
        u.dnpc = v.dnpc;
        cyc();
        u.out_ready = 1'b0;
        u.dnpc_valid = 1'b0;
        chkb("out_drop", u.out_valid, 1'b0);
        chkb("dnpc_ready", u.dnpc_ready, 1'b1);
        for (int i = 0; i < v.npc_wait; i++) begin
            u.dnpc = $urandom;
            cyc();
            chkb("dnpc_rdy_hold", u.dnpc_ready, 1'b1);
        end
        u.dnpc_valid = 1'b1;
        u.dnpc = v.dnpc;
        cyc();
        u.dnpc_valid = 1'b0;
        u.dnpc = $urandom;
        chkb("dnpc_rdy_off", u.dnpc_ready, 1'b0);
    endtask

    vec_t        tbl[7];
    vec_t        v;
    logic [31:0] mpc;
    logic [31:0] npc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        u.arready = 1'b0;
        u.rvalid = 1'b0;
        u.rdata = '0;
        u.rresp = '0;
        u.out_ready = 1'b0;
        u.dnpc = '0;
        u.dnpc_valid = 1'b0;

        cur_tag = "reset";
        cyc();
        cyc();
        chkb("arvalid", u.arvalid, 1'b0);
        chkb("rready", u.rready, 1'b0);
        chkb("out_valid", u.out_valid, 1'b0);
        chkb("out_fault", u.out_fault, 1'b0);
        chk32("out_inst", u.out_inst, 32'h0);
        chk32("out_pc", u.out_pc, RST_PC);
        chkb("dnpc_ready", u.dnpc_ready, 1'b0);
        chk32("araddr", u.araddr, RST_PC);
        rst = 1'b0;
        chkb("arvalid_rel", u.arvalid, 1'b0);
        cyc();
        chkb("first_arvalid", u.arvalid, 1'b1);

        tbl[0] = mkv(0, 0, 0, 0, 0, 32'h0010_0093, 2'b00, 32'h8000_0004,
                     32'h0010_0093, 1'b0, 32'h8000_0000);
        tbl[1] = mkv(0, 5, 0, 3, 0, 32'h1234_5678, 2'b00, 32'h8000_0010,
                     32'h1234_5678, 1'b0, 32'h8000_0004);
        tbl[2] = mkv(0, 0, 2, 0, 1, 32'hDEAD_BEEF, 2'b10, 32'h8000_0006,
                     32'h0000_0013, 1'b1, 32'h8000_0010);
        tbl[3] = mkv(1, 0, 0, 1, 0, 32'h0, 2'b00, 32'hFFFF_FFFC,
                     32'h0000_0013, 1'b1, 32'h8000_0006);
        tbl[4] = mkv(0, 1, 1, 0, 0, 32'hCAFE_F00D, 2'b01, 32'h0000_0000,
                     32'h0000_0013, 1'b1, 32'hFFFF_FFFC);
        tbl[5] = mkv(0, 0, 0, 0, 2, 32'h0000_0513, 2'b00, 32'h8000_0001,
                     32'h0000_0513, 1'b0, 32'h0000_0000);
        tbl[6] = mkv(1, 0, 0, 0, 0, 32'h0, 2'b00, 32'h8000_0100,
                     32'h0000_0013, 1'b1, 32'h8000_0001);
        for (int i = 0; i < 7; i++) begin
            cur_tag = $sformatf("tbl%0d", i);
            run_vec(tbl[i]);
        end

        mpc = 32'h8000_0100;
        for (int k = 0; k < 40; k++) begin
            cur_tag = $sformatf("rnd%0d", k);
            npc = $urandom;
            case ($urandom_range(0, 9))
                0, 1: ;
                2: npc = 32'hFFFF_FFFC;
                default: npc[1:0] = 2'b00;
            endcase
            if (k == 39) npc[1:0] = 2'b00;
            v = ref_model(mpc, $urandom,
                          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, npc);
            run_vec(v);
            mpc = npc;
        end

        cur_tag = "rst_mid";
        chkb("ar_pre", u.arvalid, 1'b1);
        u.arready = 1'b1;
        cyc();
        u.arready = 1'b0;
        chkb("in_resp", u.rready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chkb("arvalid", u.arvalid, 1'b0);
        chkb("rready", u.rready, 1'b0);
        chkb("out_valid", u.out_valid, 1'b0);
        chkb("dnpc_ready", u.dnpc_ready, 1'b0);
        chk32("araddr", u.araddr, RST_PC);
        chk32("out_pc", u.out_pc, RST_PC);
        cyc();
        rst = 1'b0;
        cyc();
        chkb("restart_ar", u.arvalid, 1'b1);
        run_vec(mkv(0, 0, 0, 0, 0, 32'h0000_0093, 2'b00, 32'h8000_0004,
                    32'h0000_0093, 1'b0, RST_PC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
